sum_accumulator: RTL and testbench

- Downstream consumer of the registered ripple-carry adder's WIDTH+1-bit sum output.
- Accumulates COUNT accepted sums into one block total, using a valid/ready handshake on both sides.
- Presents the total with a saturation flag and holds it until the consumer takes it.
- Sits between the adder datapath and a result sink (bus slave or logger).

---
 rtl/sum_acc_pkg.sv | 18 +
 rtl/sat_add.sv | 18 +
 rtl/sum_accumulator.sv | 123 ++++++++++++
 tb/tb_sum_accumulator.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_acc_pkg.sv
// Shared types, default parameters and helpers for the sum accumulator block.
package sum_acc_pkg;

  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_ACC_WIDTH = 12;
  localparam int unsigned DEF_COUNT     = 8;

  typedef enum logic [0:0] {
    ACCUM,
    HOLD
  } state_e;

  // Width of a counter that must reach COUNT inclusive.
  function automatic int unsigned cnt_width(input int unsigned count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational zero-extend and saturating add of an adder sum into the accumulator.
module sat_add #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ACC_WIDTH = 12
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [WIDTH:0]       addend,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 sat
);

  logic [ACC_WIDTH:0] full;

  assign full   = {1'b0, acc} + {{(ACC_WIDTH - WIDTH){1'b0}}, addend};
  assign sat    = full[ACC_WIDTH];
  assign result = sat ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates COUNT adder sums per block and presents a saturating total over valid/ready.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned COUNT     = DEF_COUNT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic [WIDTH:0]                sum_in,
  input  logic                          sum_valid,
  output logic                          sum_ready,
  output logic [ACC_WIDTH-1:0]          acc_out,
  output logic                          acc_valid,
  input  logic                          acc_ready,
  output logic                          overflow,
  output logic [cnt_width(COUNT)-1:0]   sample_cnt
);

  localparam int unsigned    CW   = cnt_width(COUNT);
  localparam logic [CW-1:0]  LAST = CW'(COUNT - 1);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] out_q, out_d;
  logic                 sticky_q, sticky_d;
  logic                 ovf_q, ovf_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 accept, take, last;
  logic [ACC_WIDTH-1:0] add_res;
  logic                 add_sat;

  sat_add #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_sat_add (
    .acc   (acc_q),
    .addend(sum_in),
    .result(add_res),
    .sat   (add_sat)
  );

  assign accept = sum_valid && sum_ready;
  assign take   = acc_valid && acc_ready;
  assign last   = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ACCUM;
    end else begin
      unique case (state_q)
        ACCUM:   if (accept && last) state_d = HOLD;
        HOLD:    if (take) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // Handshake outputs depend on state only, keeping sum_ready free of input paths.
  always_comb begin
    sum_ready = (state_q == ACCUM);
    acc_valid = (state_q == HOLD);
  end

  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    if (clr) begin
      acc_d    = '0;
      sticky_d = 1'b0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else if (accept) begin
      if (last) begin
        out_d    = add_res;
        ovf_d    = sticky_q | add_sat;
        acc_d    = '0;
        sticky_d = 1'b0;
        cnt_d    = '0;
      end else begin
        acc_d    = add_res;
        sticky_d = sticky_q | add_sat;
        cnt_d    = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign acc_out    = out_q;
  assign overflow   = ovf_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: three configurations share one stimulus stream, checked
// every cycle against a block-sum model plus table vectors and directed sequences.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] sum_in = '0;
  logic       sum_valid = 1'b0;
  logic       acc_ready = 1'b0;

  logic        r0, r1, r2, v0, v1, v2, f0, f1, f2;
  logic [11:0] o0, o2;
  logic [5:0]  o1;
  logic [3:0]  c0;
  logic [2:0]  c1;
  logic [0:0]  c2;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sum_accumulator u0 (
    .clk(clk), .rst(rst), .clr(clr), .sum_in(sum_in), .sum_valid(sum_valid),
    .sum_ready(r0), .acc_out(o0), .acc_valid(v0), .acc_ready(acc_ready),
    .overflow(f0), .sample_cnt(c0)
  );

  sum_accumulator #(.WIDTH(4), .ACC_WIDTH(6), .COUNT(4)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .sum_in(sum_in), .sum_valid(sum_valid),
    .sum_ready(r1), .acc_out(o1), .acc_valid(v1), .acc_ready(acc_ready),
    .overflow(f1), .sample_cnt(c1)
  );

  sum_accumulator #(.WIDTH(4), .ACC_WIDTH(12), .COUNT(1)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .sum_in(sum_in), .sum_valid(sum_valid),
    .sum_ready(r2), .acc_out(o2), .acc_valid(v2), .acc_ready(acc_ready),
    .overflow(f2), .sample_cnt(c2)
  );

  int rdy[3], vld[3], outv[3], ovf[3], cnt[3];
  always_comb begin
    rdy[0] = int'(r0);  rdy[1] = int'(r1);  rdy[2] = int'(r2);
    vld[0] = int'(v0);  vld[1] = int'(v1);  vld[2] = int'(v2);
    outv[0] = int'(o0); outv[1] = int'(o1); outv[2] = int'(o2);
    ovf[0] = int'(f0);  ovf[1] = int'(f1);  ovf[2] = int'(f2);
    cnt[0] = int'(c0);  cnt[1] = int'(c1);  cnt[2] = int'(c2);
  end

  // Reference model: a block is just the plain sum of its samples, clipped to the max.
  int cfg_count[3] = '{8, 4, 1};
  int cfg_aw[3]    = '{12, 6, 12};
  int m_hold[3], m_cnt[3], m_sum[3], m_out[3], m_ovf[3];

  always @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      int maxv;
      maxv = (1 << cfg_aw[c]) - 1;
      if (!rst) begin
        m_hold[c] = 0; m_cnt[c] = 0; m_sum[c] = 0; m_out[c] = 0; m_ovf[c] = 0;
      end else if (clr) begin
        m_hold[c] = 0; m_cnt[c] = 0; m_sum[c] = 0; m_ovf[c] = 0;
      end else if (m_hold[c] != 0) begin
        if (acc_ready) m_hold[c] = 0;
      end else if (sum_valid) begin
        m_sum[c] += int'(sum_in);
        m_cnt[c] += 1;
        if (m_cnt[c] == cfg_count[c]) begin
          m_out[c]  = (m_sum[c] > maxv) ? maxv : m_sum[c];
          m_ovf[c]  = (m_sum[c] > maxv) ? 1 : 0;
          m_hold[c] = 1;
          m_cnt[c]  = 0;
          m_sum[c]  = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("model.ready[%0d]", c), rdy[c], (m_hold[c] != 0) ? 0 : 1);
        chk($sformatf("model.valid[%0d]", c), vld[c], m_hold[c]);
        chk($sformatf("model.cnt[%0d]", c), cnt[c], m_cnt[c]);
        if (m_hold[c] != 0) begin
          chk($sformatf("model.out[%0d]", c), outv[c], m_out[c]);
          chk($sformatf("model.ovf[%0d]", c), ovf[c], m_ovf[c]);
        end
      end
    end
  end

  // All tasks start and finish just after a falling edge.
  task automatic do_reset();
    rst = 1'b0; clr = 1'b0; sum_valid = 1'b0; acc_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic feed(input int c, input int value);
    int guard = 0;
    while (rdy[c] == 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("feed.ready_timeout", rdy[c], 1);
    sum_valid = 1'b1;
    sum_in    = 5'(value);
    @(negedge clk);
    sum_valid = 1'b0;
  endtask

  task automatic wait_result(input int c, input int exp_out, input int exp_ovf);
    int guard = 0;
    chk("latency.valid", vld[c], 1);
    while (vld[c] == 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("result.out", outv[c], exp_out);
    chk("result.ovf", ovf[c], exp_ovf);
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    chk("take.valid_low", vld[c], 0);
    chk("take.ready_back", rdy[c], 1);
  endtask

  typedef struct {
    int cfg;
    bit keep;
    int n;
    int smp[8];
    int exp_out;
    int exp_ovf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 1'b0, 8, '{5, 5, 5, 5, 5, 5, 5, 5}, 40, 0};
    vecs[1] = '{1, 1'b0, 4, '{31, 31, 31, 1, 0, 0, 0, 0}, 63, 1};
    vecs[2] = '{1, 1'b1, 4, '{1, 1, 1, 1, 0, 0, 0, 0}, 4, 0};
    vecs[3] = '{0, 1'b0, 8, '{31, 31, 31, 31, 31, 31, 31, 31}, 248, 0};
    vecs[4] = '{1, 1'b0, 4, '{20, 20, 20, 3, 0, 0, 0, 0}, 63, 0};
    vecs[5] = '{1, 1'b0, 4, '{20, 20, 20, 4, 0, 0, 0, 0}, 63, 1};
    vecs[6] = '{2, 1'b0, 1, '{17, 0, 0, 0, 0, 0, 0, 0}, 17, 0};
    vecs[7] = '{2, 1'b1, 1, '{3, 0, 0, 0, 0, 0, 0, 0}, 3, 0};
    vecs[8] = '{0, 1'b0, 8, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 0};

    // Reset with a sample presented throughout.
    rst = 1'b0; sum_valid = 1'b1; sum_in = 5'd9;
    repeat (3) @(negedge clk);
    chk("reset.valid", vld[0], 0);
    chk("reset.out", outv[0], 0);
    chk("reset.ovf", ovf[0], 0);
    chk("reset.cnt", cnt[0], 0);
    rst = 1'b1; sum_valid = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset.ready_after", rdy[0], 1);

    // Table vectors.
    foreach (vecs[i]) begin
      if (!vecs[i].keep) do_reset();
      for (int j = 0; j < vecs[i].n; j++) feed(vecs[i].cfg, vecs[i].smp[j]);
      wait_result(vecs[i].cfg, vecs[i].exp_out, vecs[i].exp_ovf);
    end

    // Backpressure with gaps, then a sample presented during HOLD.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      feed(0, i);
    end
    chk("bp.valid", vld[0], 1);
    sum_valid = 1'b1; sum_in = 5'd9;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp.out_stable", outv[0], 36);
      chk("bp.ready_low", rdy[0], 0);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    chk("bp.take_valid", vld[0], 0);
    chk("bp.no_accept_on_take", cnt[0], 0);
    @(negedge clk);
    sum_valid = 1'b0;
    chk("bp.ninth_accepted", cnt[0], 1);

    // Flush mid-block, then flush in HOLD.
    do_reset();
    repeat (3) feed(0, 7);
    chk("clr.cnt_before", cnt[0], 3);
    clr = 1'b1; sum_valid = 1'b1; sum_in = 5'd7;
    @(negedge clk);
    clr = 1'b0; sum_valid = 1'b0;
    chk("clr.cnt", cnt[0], 0);
    repeat (8) feed(0, 2);
    chk("clr.hold_valid", vld[0], 1);
    chk("clr.block_out", outv[0], 16);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr.hold_dropped", vld[0], 0);
    chk("clr.ovf", ovf[0], 0);

    // Reset while a single-sample result is pending.
    do_reset();
    feed(2, 5);
    chk("rst_hold.valid_before", vld[2], 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_hold.valid", vld[2], 0);
    chk("rst_hold.out", outv[2], 0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(0, 299) != 0);
      clr       = ($urandom_range(0, 59) == 0);
      sum_valid = ($urandom_range(0, 3) != 0);
      sum_in    = 5'($urandom_range(0, 31));
      acc_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    rst = 1'b1; clr = 1'b0; sum_valid = 1'b0; acc_ready = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
